// File: rtl/leglite_pc_pkg.sv
// Shared definitions for the LEGLite program-counter unit:
// branch op codes, instruction size, next-pc source select and branch target arithmetic.
package leglite_pc_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_CBZ  = 3'd1;
    localparam logic [2:0] BR_CBNZ = 3'd2;
    localparam logic [2:0] BR_B    = 3'd3;
    localparam logic [2:0] BR_BL   = 3'd4;
    localparam logic [2:0] BR_RET  = 3'd5;

    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        NEXT_SEQ,
        NEXT_TARGET,
        NEXT_RET
    } next_sel_e;

    // Callers truncate the result to their pc width, which gives the modulo-2^N wrap.
    function automatic logic [63:0] branch_target(input logic [63:0] base,
                                                  input logic [63:0] offset);
        return base + offset * 64'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decode/ALU to pc_unit control bundle; master is the decode side, slave is pc_unit.
interface pc_unit_if #(parameter int PC_WIDTH = 16);

    logic                stall;
    logic [2:0]          br_op;
    logic                alu_zero;
    logic [PC_WIDTH-1:0] signext;
    logic [PC_WIDTH-1:0] pc;
    logic                taken;
    logic [PC_WIDTH-1:0] link;
    logic                ras_ovf;
    logic                ras_unf;

    modport master (
        output stall, br_op, alu_zero, signext,
        input  pc, taken, link, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, br_op, alu_zero, signext,
        output pc, taken, link, ras_ovf, ras_unf
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop of an empty stack is ignored (the caller treats it as underflow).
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf_evt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top_ptr = ptr_dec(wr_ptr);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign ovf_evt = push && full;

    // NOTE: storage has no reset; count alone decides which entries are valid,
    // so clearing the array would only cost reset routing.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// LEGLite fetch-stage program counter with CBZ/CBNZ/B/BL/RET redirect and return-address storage.
// Define PC_RAS_EN for a RAS_DEPTH-entry return stack; otherwise a single link register is used.
module pc_unit
    import leglite_pc_pkg::*;
#(
    parameter int                  PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    if (RAS_DEPTH < 2) begin : g_bad_depth
        $error("pc_unit: RAS_DEPTH must be at least 2");
    end

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] link_w;
    logic [PC_WIDTH-1:0] target_w;
    logic [PC_WIDTH-1:0] ret_addr;
    logic [PC_WIDTH-1:0] pc_next;
    logic                ret_valid;
    logic                advance;
    logic                push;
    logic                pop;
    logic                unf_evt;
    logic                unf_q;
    next_sel_e           sel;

    assign link_w   = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign target_w = PC_WIDTH'(branch_target(64'(pc_q), 64'(bus.signext)));

    // NOTE: sel gets its default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        sel = NEXT_SEQ;
        case (bus.br_op)
            BR_CBZ:      if (bus.alu_zero)  sel = NEXT_TARGET;
            BR_CBNZ:     if (!bus.alu_zero) sel = NEXT_TARGET;
            BR_B, BR_BL: sel = NEXT_TARGET;
            BR_RET:      if (ret_valid)     sel = NEXT_RET;
            default:     sel = NEXT_SEQ;
        endcase
    end

    always_comb begin
        pc_next = link_w;
        case (sel)
            NEXT_TARGET: pc_next = target_w;
            NEXT_RET:    pc_next = ret_addr;
            default:     pc_next = link_w;
        endcase
    end

    // A stalled cycle must leave the return storage untouched, so both strobes are gated here.
    assign advance = !bus.stall;
    assign push    = advance && (bus.br_op == BR_BL);
    assign pop     = advance && (bus.br_op == BR_RET) && ret_valid;
    assign unf_evt = advance && (bus.br_op == BR_RET) && !ret_valid;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            unf_q <= 1'b0;
        end else if (advance) begin
            pc_q <= pc_next;
            if (unf_evt) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef PC_RAS_EN
    logic ras_empty;
    logic ras_full;
    logic ovf_evt;
    logic ovf_q;

    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (link_w),
        .top     (ret_addr),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf_evt (ovf_evt)
    );

    assign ret_valid = !ras_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end
    end

    a_ovf_only_when_full: assert property (@(posedge clock) disable iff (!reset)
        ovf_evt |-> ras_full);

    assign bus.ras_ovf = ovf_q;
`else
    logic [PC_WIDTH-1:0] link_q;
    logic                link_valid_q;

    // Single-entry storage: BL always overwrites, so there is no overflow condition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            link_q       <= '0;
            link_valid_q <= 1'b0;
        end else if (push) begin
            link_q       <= link_w;
            link_valid_q <= 1'b1;
        end else if (pop) begin
            link_valid_q <= 1'b0;
        end
    end

    assign ret_addr    = link_q;
    assign ret_valid   = link_valid_q;
    assign bus.ras_ovf = 1'b0;
`endif

    assign bus.pc      = pc_q;
    assign bus.taken   = (sel != NEXT_SEQ);
    assign bus.link    = link_w;
    assign bus.ras_unf = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps followed by randomized ops,
// compared against a queue-based model of the redirect and return-stack rules.
module tb_pc_unit;

    localparam int W = 16;
`ifdef PC_RAS_EN
    localparam int  CAP     = 4;
    localparam bit  HAS_RAS = 1'b1;
`else
    localparam int  CAP     = 1;
    localparam bit  HAS_RAS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    pc_unit_if #(.PC_WIDTH(W)) bus ();

    pc_unit #(
        .PC_WIDTH  (W),
        .RESET_PC  (16'h0000),
        .RAS_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] pc_m;
    logic [W-1:0] stack_m [$];
    logic         ovf_m;
    logic         unf_m;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] op, input logic zero);
        case (op)
            3'd1:       return zero;
            3'd2:       return !zero;
            3'd3, 3'd4: return 1'b1;
            3'd5:       return stack_m.size() != 0;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        pc_m = '0;
        stack_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] op, input logic zero, input logic [W-1:0] se);
        logic [W-1:0] seq;
        logic [W-1:0] tgt;
        seq = pc_m + 16'd2;
        tgt = pc_m + {se[W-2:0], 1'b0};
        case (op)
            3'd1: pc_m = zero ? tgt : seq;
            3'd2: pc_m = zero ? seq : tgt;
            3'd3: pc_m = tgt;
            3'd4: begin
                if (stack_m.size() == CAP) begin
                    void'(stack_m.pop_front());
                    if (HAS_RAS) ovf_m = 1'b1;
                end
                stack_m.push_back(seq);
                pc_m = tgt;
            end
            3'd5: begin
                if (stack_m.size() != 0) pc_m = stack_m.pop_back();
                else begin
                    unf_m = 1'b1;
                    pc_m  = seq;
                end
            end
            default: pc_m = seq;
        endcase
    endtask

    // Entered and left at posedge+1; inputs settle, combinational outputs checked, then one edge.
    task automatic step(input string tag, input logic [2:0] op, input logic zero,
                        input logic [W-1:0] se, input logic stl);
        bus.br_op    = op;
        bus.alu_zero = zero;
        bus.signext  = se;
        bus.stall    = stl;
        #1;
        check({tag, "_taken"}, 16'(bus.taken), 16'(model_taken(op, zero)));
        check({tag, "_link"}, bus.link, pc_m + 16'd2);
        @(posedge clock);
        #1;
        if (!stl) model_edge(op, zero, se);
        check({tag, "_pc"}, bus.pc, pc_m);
        check({tag, "_ovf"}, 16'(bus.ras_ovf), 16'(ovf_m));
        check({tag, "_unf"}, 16'(bus.ras_unf), 16'(unf_m));
    endtask

    // Async reset raised between edges while a stalled BL is presented.
    task automatic async_reset(input string tag);
        bus.stall = 1'b1;
        bus.br_op = 3'd4;
        reset     = 1'b0;
        #1;
        model_reset();
        check({tag, "_pc"}, bus.pc, 16'h0000);
        check({tag, "_ovf"}, 16'(bus.ras_ovf), 16'h0);
        check({tag, "_unf"}, 16'(bus.ras_unf), 16'h0);
        @(posedge clock);
        #1;
        check({tag, "_hold_pc"}, bus.pc, 16'h0000);
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.br_op = 3'd0;
        @(posedge clock);
        #1;
        model_edge(3'd0, 1'b0, '0);
        check({tag, "_rel_pc"}, bus.pc, pc_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall    = 1'b0;
        bus.br_op    = 3'd0;
        bus.alu_zero = 1'b0;
        bus.signext  = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_ovf", 16'(bus.ras_ovf), 16'h0);
        check("rst_unf", 16'(bus.ras_unf), 16'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_edge(3'd0, 1'b0, '0);
        check("rel_pc", bus.pc, 16'h0002);

        step("seq", 3'd0, 1'b0, 16'h0, 1'b0);
        step("seq", 3'd0, 1'b0, 16'h0, 1'b0);
        check("seq_pc6", bus.pc, 16'h0006);
        step("stall", 3'd3, 1'b0, 16'h0010, 1'b1);
        step("stall", 3'd4, 1'b1, 16'h0010, 1'b1);
        check("stall_pc6", bus.pc, 16'h0006);

        step("cbz_nt", 3'd1, 1'b0, 16'h0006, 1'b0);
        check("cbz_nt_pc8", bus.pc, 16'h0008);
        step("cbz_t", 3'd1, 1'b1, 16'h0006, 1'b0);
        check("cbz_t_pc20", bus.pc, 16'd20);
        step("cbnz_t", 3'd2, 1'b0, 16'hFFFD, 1'b0);
        check("cbnz_t_pc14", bus.pc, 16'd14);
        step("cbnz_nt", 3'd2, 1'b1, 16'hFFFD, 1'b0);
        check("cbnz_nt_pc16", bus.pc, 16'd16);

        step("b_back", 3'd3, 1'b0, 16'hFFF9, 1'b0);
        check("b_back_pc2", bus.pc, 16'h0002);
        step("b_wrap", 3'd3, 1'b0, 16'hFFFE, 1'b0);
        check("b_wrap_fffe", bus.pc, 16'hFFFE);
        step("seq_wrap", 3'd0, 1'b0, 16'h0, 1'b0);
        check("seq_wrap_0", bus.pc, 16'h0000);
        step("rsvd6", 3'd6, 1'b1, 16'h0040, 1'b0);
        step("rsvd7", 3'd7, 1'b0, 16'h0040, 1'b0);
        check("rsvd_pc4", bus.pc, 16'h0004);
        step("b_to10", 3'd3, 1'b0, 16'h0003, 1'b0);

        step("bl", 3'd4, 1'b0, 16'd20, 1'b0);
        check("bl_pc50", bus.pc, 16'd50);
        step("ret", 3'd5, 1'b0, 16'h0, 1'b0);
        check("ret_pc12", bus.pc, 16'd12);
        step("ret_unf", 3'd5, 1'b0, 16'h0, 1'b0);
        check("ret_unf_pc14", bus.pc, 16'd14);
        check("ret_unf_flag", 16'(bus.ras_unf), 16'h1);

        async_reset("arst1");

        for (int i = 0; i < 5; i++) step("nest_bl", 3'd4, 1'b0, 16'd10, 1'b0);
`ifdef PC_RAS_EN
        check("nest_ovf", 16'(bus.ras_ovf), 16'h1);
`endif
        for (int i = 0; i < 5; i++) step("nest_ret", 3'd5, 1'b0, 16'h0, 1'b0);
        check("nest_unf", 16'(bus.ras_unf), 16'h1);
        async_reset("arst2");

        for (int i = 0; i < 400; i++) begin
            int           v;
            logic [2:0]   op;
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_arst");
            end else begin
                v  = int'($urandom_range(0, 40)) - 20;
                op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(4, 5))
                                                 : 3'($urandom_range(0, 7));
                step("rnd", op, 1'($urandom_range(0, 1)), 16'(v),
                     $urandom_range(0, 4) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
